uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of uart_rxd synchronizer flops (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port cfg_div, input, 16, clocks per bit period; values below 4 are treated as 4.
REQ-005 SHALL have port cfg_rxen, input, 1, receiver enable.
REQ-006 SHALL have port cfg_nstop, input, 1, stop bits: 0 = one, 1 = two.
REQ-007 SHALL have port uart_rxd, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port rx_valid, output, 1, received byte available.
REQ-009 SHALL have port rx_data, output, 8, received byte.
REQ-010 SHALL have port rx_ready, input, 1, consumer accepts the byte.
REQ-011 SHALL have port rx_frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port rx_overrun, output, 1, one-cycle pulse on a dropped byte.

Function
REQ-013 SHALL pass uart_rxd through SYNC_STAGES flops; all line decisions use the synchronized value "rxs".
REQ-014 SHALL implement the states IDLE, START, DATA and STOP, plus a 16-bit bit timer and a 3-bit bit counter.
REQ-015 SHALL leave IDLE for START only on a rxs 1-to-0 transition while cfg_rxen=1, clearing the timer to 0 and latching cfg_div (clamped) and cfg_nstop for the frame.
REQ-016 SHALL, in START, sample at timer==div>>1; a sampled 1 returns the block to IDLE (false start, no output); a sampled 0 enters DATA with timer=0 and bit counter=0.
REQ-017 SHALL, in DATA and STOP, sample when timer==div-1 and then wrap the timer to 0; otherwise the timer increments by 1.
REQ-018 SHALL shift data in LSB first; after the 8th sample it enters STOP.
REQ-019 SHALL, in STOP, take one sample (cfg_nstop=0) or two samples (cfg_nstop=1); any sampled 0 marks a framing error.
REQ-020 SHALL, on the final stop sample, return to IDLE and deliver the byte in the next cycle, unless a framing error occurred, in which case the byte is discarded and rx_frame_err pulses for one cycle.
REQ-021 SHALL hold rx_valid high and rx_data stable until a cycle with rx_valid & rx_ready; rx_valid falls in the following cycle.
REQ-022 SHALL, when a delivery coincides with rx_valid=1 & rx_ready=0, keep the old byte, drop the new one, and pulse rx_overrun for one cycle.
REQ-023 SHALL, when a delivery coincides with rx_valid=1 & rx_ready=1, load the new byte, keep rx_valid=1, and not flag an overrun.
REQ-024 SHALL, on cfg_rxen=0 in any non-IDLE state, abort to IDLE next cycle with no delivery and no error; a pending rx_valid and rx_data are retained.
REQ-025 SHALL require a new 1-to-0 edge after a frame ends, so a held-low line (break) produces exactly one frame error and no further frames.
REQ-026 SHALL make cfg_div changes mid-frame take no effect until the next start bit.

Reset
REQ-027 SHALL, on rst=1 at a clk edge, set the state to IDLE, the synchronizer flops to 1, timer and bit counter to 0, and rx_valid, rx_frame_err and rx_overrun to 0.
REQ-028 SHALL also clear rx_data to 0x00 on reset.
REQ-029 SHALL abandon any frame in progress on reset and retain no partial byte.

Configuration
REQ-030 SHALL, with macro UART_RX_MAJORITY_EN defined, decide each sample (start, data, stop) by 2-of-3 majority of rxs over the sample cycle and the two preceding cycles.
REQ-031 SHALL, without UART_RX_MAJORITY_EN, use the single rxs value at the sample cycle; the ports are identical in both builds.

Verification
REQ-032 SHALL check: cfg_div=16, cfg_nstop=0, rx_ready=1, frame 0xA5 -> rx_data=0xA5, rx_valid high for exactly one cycle, no error pulses.
REQ-033 SHALL check: cfg_nstop=1, frame 0x3C with its second stop bit driven 0 -> one rx_frame_err pulse, no rx_valid, and the next frame 0x81 is received correctly.
REQ-034 SHALL check: rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x11, one rx_overrun pulse; then rx_ready=1 -> 0x11 is consumed.
REQ-035 SHALL check: a 3-clock low glitch at cfg_div=16 -> START rejects it and the block returns to IDLE with no output.
REQ-036 SHALL check: cfg_rxen dropped mid-DATA, and separately rst asserted mid-DATA -> the block is in IDLE, no rx_valid, and reset output values per REQ-027/028.
REQ-037 SHALL check: with UART_RX_MAJORITY_EN defined, a 1-clock inverted glitch at a data sample point of 0x5A -> rx_data=0x5A.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: synchronized line, start-bit validation, LSB-first 8-bit frames, 1/2 stop bits.
// Define UART_RX_MAJORITY_EN to decide every sample by 2-of-3 majority over the last three rxs values.
module uart_rx #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cfg_div,
   input  logic        cfg_rxen,
   input  logic        cfg_nstop,
   input  logic        uart_rxd,
   output logic        rx_valid,
   output logic [7:0]  rx_data,
   input  logic        rx_ready,
   output logic        rx_frame_err,
   output logic        rx_overrun
);

   localparam int unsigned LP_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [LP_STAGES-1:0] r_sync;
   logic                 r_rxs_d1;
   logic                 w_rxs;
   logic                 w_fall;
   logic                 w_bit;

   logic [15:0]          r_timer;
   logic [15:0]          r_div;
   logic [2:0]           r_bitcnt;
   logic                 r_nstop;
   logic                 r_stopcnt;
   logic                 r_ferr;
   logic [7:0]           r_shift;

   logic [15:0]          w_div_eff;
   logic [15:0]          w_div_m1;
   logic [15:0]          w_half;
   logic                 w_bit_tick;
   logic                 w_start_ok;
   logic                 w_data_smp;
   logic                 w_stop_smp;
   logic                 w_fin;
   logic                 w_ferr_final;

   assign w_rxs  = r_sync[LP_STAGES-1];
   assign w_fall = r_rxs_d1 & ~w_rxs;

`ifdef UART_RX_MAJORITY_EN
   logic r_rxs_d2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rxs_d2 <= 1'b1;
      end else begin
         r_rxs_d2 <= r_rxs_d1;
      end
   end

   assign w_bit = (w_rxs & r_rxs_d1) | (w_rxs & r_rxs_d2) | (r_rxs_d1 & r_rxs_d2);
`else
   assign w_bit = w_rxs;
`endif

   assign w_div_eff    = (cfg_div < 16'd4) ? 16'd4 : cfg_div;
   assign w_div_m1     = r_div - 16'd1;
   assign w_half       = {1'b0, r_div[15:1]};
   assign w_bit_tick   = (r_timer == w_div_m1);
   assign w_ferr_final = r_ferr | ~w_bit;

   // Next-state and sample strobes; every abort path goes through the cfg_rxen check first.
   always_comb begin
      w_state_nxt = r_state;
      w_start_ok  = 1'b0;
      w_data_smp  = 1'b0;
      w_stop_smp  = 1'b0;
      w_fin       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (cfg_rxen && w_fall) begin
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (!cfg_rxen) begin
               w_state_nxt = ST_IDLE;
            end else if (r_timer == w_half) begin
               if (w_bit) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_DATA;
                  w_start_ok  = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (!cfg_rxen) begin
               w_state_nxt = ST_IDLE;
            end else if (w_bit_tick) begin
               w_data_smp = 1'b1;
               if (r_bitcnt == 3'd7) begin
                  w_state_nxt = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (!cfg_rxen) begin
               w_state_nxt = ST_IDLE;
            end else if (w_bit_tick) begin
               w_stop_smp = 1'b1;
               if (r_stopcnt == r_nstop) begin
                  w_fin       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync   <= '1;
         r_rxs_d1 <= 1'b1;
      end else begin
         r_sync   <= {r_sync[LP_STAGES-2:0], uart_rxd};
         r_rxs_d1 <= w_rxs;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_timer   <= '0;
         r_div     <= 16'd4;
         r_bitcnt  <= '0;
         r_nstop   <= 1'b0;
         r_stopcnt <= 1'b0;
         r_ferr    <= 1'b0;
         r_shift   <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_state_nxt == ST_START) begin
                  r_timer   <= '0;
                  r_div     <= w_div_eff;
                  r_nstop   <= cfg_nstop;
                  r_bitcnt  <= '0;
                  r_stopcnt <= 1'b0;
                  r_ferr    <= 1'b0;
               end
            end
            ST_START: begin
               if (w_start_ok) begin
                  r_timer  <= '0;
                  r_bitcnt <= '0;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            ST_DATA, ST_STOP: begin
               r_timer <= w_bit_tick ? 16'd0 : (r_timer + 16'd1);
               if (w_data_smp) begin
                  r_shift  <= {w_bit, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 3'd1;
               end
               if (w_stop_smp) begin
                  r_stopcnt <= 1'b1;
                  if (!w_bit) begin
                     r_ferr <= 1'b1;
                  end
               end
            end
            default: begin
               r_timer <= '0;
            end
         endcase
      end
   end

   // Output holding register: a delivery that lands while a byte is still pending is
   // either a replace (consumer accepting this cycle) or an overrun drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_valid     <= 1'b0;
         rx_data      <= '0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
      end else begin
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         if (w_fin) begin
            if (w_ferr_final) begin
               rx_frame_err <= 1'b1;
            end else if (rx_valid && !rx_ready) begin
               rx_overrun <= 1'b1;
            end else begin
               rx_valid <= 1'b1;
               rx_data  <= r_shift;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, framing error, overrun, false start, abort and reset.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cfg_div = 16'd16;
   logic        cfg_rxen = 1'b1;
   logic        cfg_nstop = 1'b0;
   logic        uart_rxd = 1'b1;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready = 1'b1;
   logic        rx_frame_err;
   logic        rx_overrun;

   int unsigned checks = 0;
   int unsigned failures = 0;

   int unsigned n_valid = 0;
   int unsigned n_acc = 0;
   int unsigned n_ferr = 0;
   int unsigned n_ovr = 0;
   logic [7:0]  acc_data = '0;

   int unsigned s_valid, s_acc, s_ferr, s_ovr;

   uart_rx #(.SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_div      (cfg_div),
      .cfg_rxen     (cfg_rxen),
      .cfg_nstop    (cfg_nstop),
      .uart_rxd     (uart_rxd),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) n_valid++;
         if (rx_valid && rx_ready) begin
            n_acc++;
            acc_data = rx_data;
         end
         if (rx_frame_err) n_ferr++;
         if (rx_overrun) n_ovr++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish within 2 ms");
      $fatal(1);
   end

   task automatic snap();
      s_valid = n_valid;
      s_acc   = n_acc;
      s_ferr  = n_ferr;
      s_ovr   = n_ovr;
   endtask

   task automatic idle(input int unsigned n);
      uart_rxd = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v, input logic glitch);
      for (int unsigned c = 0; c < 32'(cfg_div); c++) begin
         uart_rxd = (glitch && c == 9) ? ~v : v;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_last_stop, input int glitch_bit);
      @(posedge clk);
      #1;
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i], glitch_bit == i);
      if (cfg_nstop) drive_bit(1'b1, 1'b0);
      drive_bit(!bad_last_stop, 1'b0);
      idle(6);
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      @(posedge clk);
      #1;
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(b[i], 1'b0);
      uart_rxd = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
      checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", rx_frame_err); end
      checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", rx_overrun); end
      rst = 1'b0;
      idle(4);
   endtask

   task automatic test_basic();
      cfg_div = 16'd16; cfg_nstop = 1'b0; rx_ready = 1'b1;
      snap();
      send_frame(8'hA5, 1'b0, -1);
      checks++; if (n_valid - s_valid !== 1) begin failures++; $display("FAIL basic_valid_cycles got=%0d exp=1", n_valid - s_valid); end
      checks++; if (acc_data !== 8'hA5) begin failures++; $display("FAIL basic_acc_data got=%h exp=a5", acc_data); end
      checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL basic_rx_data got=%h exp=a5", rx_data); end
      checks++; if (n_ferr - s_ferr !== 0) begin failures++; $display("FAIL basic_ferr got=%0d exp=0", n_ferr - s_ferr); end
      checks++; if (n_ovr - s_ovr !== 0) begin failures++; $display("FAIL basic_ovr got=%0d exp=0", n_ovr - s_ovr); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_after got=%b exp=0", rx_valid); end
   endtask

   task automatic test_frame_err();
      cfg_nstop = 1'b1; rx_ready = 1'b1;
      snap();
      send_frame(8'h3C, 1'b1, -1);
      idle(20);
      checks++; if (n_ferr - s_ferr !== 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", n_ferr - s_ferr); end
      checks++; if (n_valid - s_valid !== 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", n_valid - s_valid); end
      snap();
      send_frame(8'h81, 1'b0, -1);
      checks++; if (n_valid - s_valid !== 1) begin failures++; $display("FAIL ferr_next_valid got=%0d exp=1", n_valid - s_valid); end
      checks++; if (acc_data !== 8'h81) begin failures++; $display("FAIL ferr_next_data got=%h exp=81", acc_data); end
      checks++; if (n_ferr - s_ferr !== 0) begin failures++; $display("FAIL ferr_next_ferr got=%0d exp=0", n_ferr - s_ferr); end
      cfg_nstop = 1'b0;
   endtask

   task automatic test_overrun();
      rx_ready = 1'b0;
      snap();
      send_frame(8'h11, 1'b0, -1);
      send_frame(8'h22, 1'b0, -1);
      checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
      checks++; if (rx_data !== 8'h11) begin failures++; $display("FAIL ovr_data got=%h exp=11", rx_data); end
      checks++; if (n_ovr - s_ovr !== 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", n_ovr - s_ovr); end
      snap();
      rx_ready = 1'b1;
      idle(3);
      checks++; if (n_acc - s_acc !== 1) begin failures++; $display("FAIL ovr_consume_count got=%0d exp=1", n_acc - s_acc); end
      checks++; if (acc_data !== 8'h11) begin failures++; $display("FAIL ovr_consume_data got=%h exp=11", acc_data); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_valid_after got=%b exp=0", rx_valid); end
   endtask

   task automatic test_glitch();
      cfg_div = 16'd16; rx_ready = 1'b1;
      snap();
      @(posedge clk); #1;
      uart_rxd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      idle(40);
      checks++; if (n_valid - s_valid !== 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", n_valid - s_valid); end
      checks++; if (n_ferr - s_ferr !== 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", n_ferr - s_ferr); end
      checks++; if (n_ovr - s_ovr !== 0) begin failures++; $display("FAIL glitch_ovr got=%0d exp=0", n_ovr - s_ovr); end
      snap();
      send_frame(8'h42, 1'b0, -1);
      checks++; if (n_valid - s_valid !== 1) begin failures++; $display("FAIL glitch_next_valid got=%0d exp=1", n_valid - s_valid); end
      checks++; if (acc_data !== 8'h42) begin failures++; $display("FAIL glitch_next_data got=%h exp=42", acc_data); end
   endtask

   task automatic test_rxen_abort();
      rx_ready = 1'b0;
      send_frame(8'h5C, 1'b0, -1);
      snap();
      send_partial(8'hF0, 3);
      cfg_rxen = 1'b0;
      idle(5);
      cfg_rxen = 1'b1;
      idle(200);
      checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL abort_valid_kept got=%b exp=1", rx_valid); end
      checks++; if (rx_data !== 8'h5C) begin failures++; $display("FAIL abort_data_kept got=%h exp=5c", rx_data); end
      checks++; if (n_ferr - s_ferr !== 0) begin failures++; $display("FAIL abort_ferr got=%0d exp=0", n_ferr - s_ferr); end
      checks++; if (n_ovr - s_ovr !== 0) begin failures++; $display("FAIL abort_ovr got=%0d exp=0", n_ovr - s_ovr); end
      rx_ready = 1'b1;
      idle(3);
      snap();
      send_frame(8'h96, 1'b0, -1);
      checks++; if (n_valid - s_valid !== 1) begin failures++; $display("FAIL abort_next_valid got=%0d exp=1", n_valid - s_valid); end
      checks++; if (acc_data !== 8'h96) begin failures++; $display("FAIL abort_next_data got=%h exp=96", acc_data); end
   endtask

   task automatic test_reset_mid();
      rx_ready = 1'b0;
      send_frame(8'h77, 1'b0, -1);
      send_partial(8'hF0, 4);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", rx_data); end
      checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_ferr got=%b exp=0", rx_frame_err); end
      checks++; if (rx_overrun !== 1'b0) begin failures++; $display("FAIL rstmid_ovr got=%b exp=0", rx_overrun); end
      rx_ready = 1'b1;
      snap();
      idle(200);
      checks++; if (n_valid - s_valid !== 0) begin failures++; $display("FAIL rstmid_no_output got=%0d exp=0", n_valid - s_valid); end
      snap();
      send_frame(8'hC3, 1'b0, -1);
      checks++; if (acc_data !== 8'hC3) begin failures++; $display("FAIL rstmid_next_data got=%h exp=c3", acc_data); end
      checks++; if (n_valid - s_valid !== 1) begin failures++; $display("FAIL rstmid_next_valid got=%0d exp=1", n_valid - s_valid); end
   endtask

`ifdef UART_RX_MAJORITY_EN
   task automatic test_majority();
      rx_ready = 1'b1;
      snap();
      send_frame(8'h5A, 1'b0, 3);
      checks++; if (acc_data !== 8'h5A) begin failures++; $display("FAIL majority_data got=%h exp=5a", acc_data); end
      checks++; if (n_valid - s_valid !== 1) begin failures++; $display("FAIL majority_valid got=%0d exp=1", n_valid - s_valid); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_frame_err();
      test_overrun();
      test_glitch();
      test_rxen_abort();
      test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
      test_majority();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
